// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end and control logic:
//   - funct opcode constants (fresh-operand and chained-with-previous forms)
//   - keypad key-code constants
//   - state encoding of the operator encoder FSM
//   - small key-classification helper
// ---------------------------------------------------------------------------
package calc_pkg;

    // Opcodes: bit 2 selects "use previous result", bits 1:0 the operator.
    localparam logic [2:0] ADD          = 3'b000;
    localparam logic [2:0] SUB          = 3'b001;
    localparam logic [2:0] MULT         = 3'b010;
    localparam logic [2:0] DIV          = 3'b011;
    localparam logic [2:0] ADDToPrev    = 3'b100;
    localparam logic [2:0] SUBToPrev    = 3'b101;
    localparam logic [2:0] MULTWithPrev = 3'b110;
    localparam logic [2:0] DIVByPrev    = 3'b111;

    // Key codes delivered by the keypad scanner.
    localparam logic [2:0] KEY_PLUS   = 3'd0;
    localparam logic [2:0] KEY_MINUS  = 3'd1;
    localparam logic [2:0] KEY_TIMES  = 3'd2;
    localparam logic [2:0] KEY_DIVIDE = 3'd3;
    localparam logic [2:0] KEY_EQUALS = 3'd4;
    localparam logic [2:0] KEY_CLEAR  = 3'd5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } calcState_e;

    // Operator keys are codes 0..3, so the low two bits are the operator.
    function automatic logic isOperatorKey(input logic [2:0] code);
        return (code <= KEY_DIVIDE);
    endfunction

    // Codes 6 and 7 are reserved.
    function automatic logic isReservedKey(input logic [2:0] code);
        return (code > KEY_CLEAR);
    endfunction

endpackage

// File: rtl/calc_op_encoder.sv
// ---------------------------------------------------------------------------
// calc_op_encoder
// Turns operator key events into funct opcodes for the calculator control
// logic, one operation at a time.  The opcode is the fresh-operand form
// until an operation has completed, after which the chained form is used.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    one-cycle key event strobe
//   key_code     key identity (0..3 operators, 4 equals, 5 clear, 6/7 reserved)
//   key_ready    high in IDLE: a non-clear key will be accepted
//   funct        opcode to the control logic
//   funct_valid  funct is presented (ISSUE state)
//   funct_ready  control logic accepts funct
//   op_done      datapath completed the issued operation (pulse)
//   has_prev     a previous result exists
//   show_result  one-cycle pulse after equals
//   err          sticky error (reserved key or overrun), cleared by clear
//   op_count     completed operations, saturating
// ---------------------------------------------------------------------------
module calc_op_encoder
    import calc_pkg::*;
#(
    parameter int FUNCT_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [2:0]         key_code,
    output logic               key_ready,
    output logic [FUNCT_W-1:0] funct,
    output logic               funct_valid,
    input  logic               funct_ready,
    input  logic               op_done,
    output logic               has_prev,
    output logic               show_result,
    output logic               err,
    output logic [CNT_W-1:0]   op_count
);

    calcState_e         stateReg,      stateNext;
    logic [FUNCT_W-1:0] functReg,      functNext;
    logic               hasPrevReg,    hasPrevNext;
    logic               showResultReg, showResultNext;
    logic               errReg,        errNext;
    logic [CNT_W-1:0]   opCountReg,    opCountNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg      <= IDLE;
            functReg      <= '0;
            hasPrevReg    <= 1'b0;
            showResultReg <= 1'b0;
            errReg        <= 1'b0;
            opCountReg    <= '0;
        end else begin
            stateReg      <= stateNext;
            functReg      <= functNext;
            hasPrevReg    <= hasPrevNext;
            showResultReg <= showResultNext;
            errReg        <= errNext;
            opCountReg    <= opCountNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        functNext      = functReg;
        hasPrevNext    = hasPrevReg;
        showResultNext = 1'b0;
        errNext        = errReg;
        opCountNext    = opCountReg;

        // Normal sequencing driven by the control-logic handshake.
        unique case (stateReg)
            ISSUE: begin
                if (funct_ready) begin
                    stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (op_done) begin
                    stateNext   = IDLE;
                    hasPrevNext = 1'b1;
                    if (opCountReg != {CNT_W{1'b1}}) begin
                        opCountNext = opCountReg + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // Key handling.  Clear overrides everything above, including an
        // op_done arriving in the same cycle: the operation is abandoned and
        // does not count.
        if (key_valid) begin
            if (key_code == KEY_CLEAR) begin
                stateNext   = IDLE;
                hasPrevNext = 1'b0;
                errNext     = 1'b0;
                opCountNext = opCountReg;
            end else if (isReservedKey(key_code)) begin
                errNext = 1'b1;
            end else if (stateReg != IDLE) begin
                // Overrun: key dropped, sequencing continues untouched.
                errNext = 1'b1;
            end else if (isOperatorKey(key_code)) begin
                functNext = FUNCT_W'({hasPrevReg, key_code[1:0]});
                stateNext = ISSUE;
            end else begin
                showResultNext = 1'b1;   // equals
            end
        end
    end

    assign key_ready   = (stateReg == IDLE);
    assign funct_valid = (stateReg == ISSUE);
    assign funct       = functReg;
    assign has_prev    = hasPrevReg;
    assign show_result = showResultReg;
    assign err         = errReg;
    assign op_count    = opCountReg;

endmodule

// File: tb/tb_calc_op_encoder.sv
// ---------------------------------------------------------------------------
// tb_calc_op_encoder
// Directed self-checking bench for calc_op_encoder.  Inputs change 1 ns
// after the rising edge; outputs are compared at that same point, so every
// check sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_calc_op_encoder;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [2:0] key_code;
    logic       key_ready;
    logic [2:0] funct;
    logic       funct_valid;
    logic       funct_ready;
    logic       op_done;
    logic       has_prev;
    logic       show_result;
    logic       err;
    logic [7:0] op_count;

    int compareCount  = 0;
    int mismatchCount = 0;

    calc_op_encoder #(
        .FUNCT_W(3),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .funct      (funct),
        .funct_valid(funct_valid),
        .funct_ready(funct_ready),
        .op_done    (op_done),
        .has_prev   (has_prev),
        .show_result(show_result),
        .err        (err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end else begin
            $display("ok   %s: %0h", tag, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle key strobe.
    task automatic pressKey(input logic [2:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 3'd0;
    endtask

    task automatic pulseDone();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkVal({pfx, ".funct"},       32'(funct),       32'd0);
        checkVal({pfx, ".funct_valid"}, 32'(funct_valid), 32'd0);
        checkVal({pfx, ".key_ready"},   32'(key_ready),   32'd1);
        checkVal({pfx, ".has_prev"},    32'(has_prev),    32'd0);
        checkVal({pfx, ".show_result"}, 32'(show_result), 32'd0);
        checkVal({pfx, ".err"},         32'(err),         32'd0);
        checkVal({pfx, ".op_count"},    32'(op_count),    32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        key_valid   = 1'b0;
        key_code    = 3'd0;
        funct_ready = 1'b1;
        op_done     = 1'b0;

        // Reset state
        tick();
        tick();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick();

        // Plus with funct_ready high: one valid cycle of ADD, then done
        pressKey(3'd0);
        checkVal("plus.funct",       32'(funct),       32'b000);
        checkVal("plus.funct_valid", 32'(funct_valid), 32'd1);
        checkVal("plus.key_ready",   32'(key_ready),   32'd0);
        tick();
        checkVal("plus.valid_drop",  32'(funct_valid), 32'd0);
        checkVal("plus.wait_ready",  32'(key_ready),   32'd0);
        pulseDone();
        checkVal("plus.has_prev",    32'(has_prev),    32'd1);
        checkVal("plus.op_count",    32'(op_count),    32'd1);
        checkVal("plus.idle",        32'(key_ready),   32'd1);

        // Divide with previous result, held off by funct_ready for 5 cycles
        funct_ready = 1'b0;
        pressKey(3'd3);
        for (int i = 0; i < 5; i++) begin
            checkVal($sformatf("hold%0d.funct", i),       32'(funct),       32'b111);
            checkVal($sformatf("hold%0d.funct_valid", i), 32'(funct_valid), 32'd1);
            if (i < 4) tick();
        end
        funct_ready = 1'b1;
        tick();
        checkVal("div.valid_drop", 32'(funct_valid), 32'd0);
        pulseDone();
        checkVal("div.op_count",   32'(op_count),    32'd2);

        // Overrun during WAIT_DONE, then clear abandons the operation
        pressKey(3'd0);
        checkVal("chain.funct", 32'(funct), 32'b100);
        tick();
        pressKey(3'd2);
        checkVal("overrun.err",         32'(err),         32'd1);
        checkVal("overrun.funct_valid", 32'(funct_valid), 32'd0);
        checkVal("overrun.funct",       32'(funct),       32'b100);
        checkVal("overrun.key_ready",   32'(key_ready),   32'd0);
        pressKey(3'd5);
        checkVal("clear.err",       32'(err),       32'd0);
        checkVal("clear.has_prev",  32'(has_prev),  32'd0);
        checkVal("clear.key_ready", 32'(key_ready), 32'd1);
        pulseDone();
        checkVal("late_done.op_count", 32'(op_count), 32'd2);
        checkVal("late_done.has_prev", 32'(has_prev), 32'd0);

        // Reserved keys and equals in IDLE
        pressKey(3'd6);
        checkVal("rsv6.err",         32'(err),         32'd1);
        checkVal("rsv6.funct_valid", 32'(funct_valid), 32'd0);
        pressKey(3'd7);
        checkVal("rsv7.err",         32'(err),         32'd1);
        checkVal("rsv7.funct_valid", 32'(funct_valid), 32'd0);
        checkVal("rsv7.key_ready",   32'(key_ready),   32'd1);
        pressKey(3'd4);
        checkVal("equals.show",     32'(show_result), 32'd1);
        checkVal("equals.has_prev", 32'(has_prev),    32'd0);
        tick();
        checkVal("equals.show_off", 32'(show_result), 32'd0);
        pressKey(3'd5);
        checkVal("clear2.err", 32'(err), 32'd0);

        // Fresh minus after clear uses the non-chained opcode
        pressKey(3'd1);
        checkVal("minus.funct", 32'(funct), 32'b001);
        tick();
        pulseDone();
        checkVal("minus.op_count", 32'(op_count), 32'd3);

        // Saturation: run up to 255, then one more
        for (int n = 3; n < 255; n++) begin
            pressKey(3'd2);
            tick();
            pulseDone();
        end
        checkVal("sat.op_count_255", 32'(op_count), 32'd255);
        pressKey(3'd2);
        checkVal("sat.funct", 32'(funct), 32'b110);
        tick();
        pulseDone();
        checkVal("sat.op_count_hold", 32'(op_count), 32'd255);

        // Asynchronous reset in the middle of ISSUE
        funct_ready = 1'b0;
        pressKey(3'd1);
        checkVal("pre_rst.funct",       32'(funct),       32'b101);
        checkVal("pre_rst.funct_valid", 32'(funct_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        tick();
        rst_n = 1'b1;
        funct_ready = 1'b1;
        tick();
        checkVal("post_rst.key_ready", 32'(key_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/calc_op_encoder.md
# calc_op_encoder

Command-issuing front end for the calculator datapath. It turns operator key events into 3-bit `funct` opcodes for the calculator control logic. It tracks whether a previous result exists, and uses that to choose the fresh-operand opcode (`ADD`..`DIV`) or the chained opcode (`ADDToPrev`..`DIVByPrev`). It sits between the keypad scanner and the control-logic decoder, and sequences one operation at a time over a valid/ready handshake plus a completion strobe.

## Interface
- `FUNCT_W`, default 3: opcode width; fixed, must match the control-logic decoder.
- `CNT_W`, default 8: width of the completed-operation counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle key event strobe.
- `key_code`  in  3  key identity:
  - 0 = plus, 1 = minus, 2 = times, 3 = divide, 4 = equals, 5 = clear.
  - 6 and 7 are reserved.
- `key_ready`  out  1  high when a non-clear key will be accepted.
- `funct`  out  `FUNCT_W`  opcode to the control logic.
- `funct_valid`  out  1  `funct` is presented.
- `funct_ready`  in  1  the control logic accepts `funct`.
- `op_done`  in  1  the datapath has completed the issued operation; single-cycle pulse.
- `has_prev`  out  1  a stored previous result exists.
- `show_result`  out  1  one-cycle pulse on equals.
- `err`  out  1  sticky error flag.
- `op_count`  out  `CNT_W`  completed operations, saturating.

## Operation
- States:
  - IDLE: `key_ready`=1.
  - ISSUE: `funct_valid`=1.
  - WAIT_DONE: waiting for `op_done`.
- IDLE, operator key (codes 0–3):
  - `funct` <= {`has_prev`, `key_code[1:0]`}.
  - Go to ISSUE.
  - With `has_prev`=0 this gives 000–011. With `has_prev`=1 it gives 100–111.
- ISSUE:
  - `funct` is held stable until `funct_ready`=1 while `funct_valid`=1.
  - On that handshake cycle, go to WAIT_DONE.
- WAIT_DONE, on `op_done`:
  - Go to IDLE and set `has_prev`.
  - `op_count` increments, saturating at all-ones.
  - `op_done` in IDLE or ISSUE is ignored.
- IDLE, equals (code 4): `show_result` pulses for one cycle. No state change; `has_prev` is unchanged.
- Clear (code 5) is accepted in every state, regardless of `key_ready`:
  - Go to IDLE.
  - `has_prev`, `err` and `funct_valid` are cleared.
  - `op_count` is not cleared.
  - A clear in ISSUE withdraws the unaccepted opcode.
  - A clear in WAIT_DONE abandons the in-flight operation; its later `op_done` is ignored.
- Reserved codes (6 and 7) in any state set `err`. There is no other effect.
- A non-clear key arriving while not in IDLE is dropped and sets `err` (overrun).
- `err` is cleared only by clear or reset.

## Timing
- Reset values:
  - State = IDLE.
  - `funct`=000, `funct_valid`=0, `key_ready`=1.
  - `has_prev`=0, `show_result`=0, `err`=0, `op_count`=0.
- Key-to-issue latency: an operator key sampled at edge N gives `funct_valid`=1 from edge N+1.
- Handshake: transfer occurs on the edge where `funct_valid` && `funct_ready`. `funct_valid` is 0 from the following cycle.
- Earliest `op_done` is honoured one cycle after the handshake edge. The minimum key-to-key spacing is therefore 3 cycles.
- `show_result` is high exactly during the cycle after equals is sampled.
- `key_ready` is a registered state decode. It is 0 in ISSUE and WAIT_DONE.
- Asserting `rst_n`=0 mid-operation forces reset values immediately, without waiting for a clock edge. Release is synchronous in effect: the first edge with `rst_n`=1 evaluates from IDLE.
- Outputs are registered or pure state decodes. There is no combinational path from `funct_ready` or `op_done` to any output.

## Structure
- The shared package `calc_pkg` holds:
  - the 8 `funct` opcode constants (`ADD`, `SUB`, `MULT`, `DIV`, `ADDToPrev`, `SUBToPrev`, `MULTWithPrev`, `DIVByPrev`), shared with the control-logic decoder;
  - the key-code constants;
  - the 3-state state encoding.
- Single module; no sub-module is warranted.

## Test plan
- Reset, then key plus with `funct_ready`=1, then `op_done` two cycles later -> `funct`=000 for one valid cycle, then `has_prev`=1 and `op_count`=1.
- With `has_prev`=1, key divide and hold `funct_ready`=0 for 5 cycles -> `funct`=111 stable and valid for all 5 cycles. After `funct_ready`, `funct_valid` drops the next cycle.
- Key times during WAIT_DONE -> key dropped, `err`=1, no new `funct`. Then clear -> `err`=0, `has_prev`=0, state IDLE, and the late `op_done` leaves `op_count` unchanged.
- Key codes 6 and 7 in IDLE -> `err`=1, `funct_valid` stays 0. Equals -> single-cycle `show_result`.
- Force `op_count`=255 via 255 completed operations, then one more -> `op_count` stays 255. Pull `rst_n` low mid-ISSUE -> all outputs return to their reset values without a clock edge.
